// File: rtl/mem_ctrl.sv
// Memory-side stage of the bus datapath: sequences single-word RAM accesses and feeds the MDR.
// Latency: accept edge E, done high in the cycle after edge E+WAIT_STATES+1.
// Backpressure: requests are only sampled in IDLE. busy marks an access in flight, and inputs are ignored while it is high.
//
// Ports:
//   clk, clear        rising-edge clock, asynchronous active-high reset
//   marOut, mdrOut    access address and write data, latched when a request is accepted
//   read, write       level requests; both high at once is rejected with a one-cycle err pulse
//   MDataIn           registered read data; holds its value until the next read transfer
//   mdrRead/mdrEnable asserted in the DONE cycle of a read so the MDR loads MDataIn
//   busy, done, err   status outputs
module mem_ctrl #(
  parameter int BITS        = 32,
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [ADDR_BITS-1:0] marOut,
  input  logic [BITS-1:0]      mdrOut,
  input  logic                 read,
  input  logic                 write,
  output logic [BITS-1:0]      MDataIn,
  output logic                 mdrRead,
  output logic                 mdrEnable,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_XFER, ST_DONE} state_t;

  state_t               state, next_state;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [BITS-1:0]      wdata_q;
  logic                 op_rd;
  logic                 err_q;
  logic                 accept;

  logic [BITS-1:0] ram [2**ADDR_BITS];

  // A request is taken only when exactly one of read/write is high.
  assign accept = (state == ST_IDLE) && (read ^ write);

  // State register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_XFER;
      ST_WAIT: if (cnt == 4'd1) next_state = ST_XFER;
      ST_XFER: next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode. err is the only status flag held in a register, because it
  // reports a rejected request and is not tied to any FSM state.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    mdrRead   = (state == ST_DONE) && op_rd;
    mdrEnable = (state == ST_DONE) && op_rd;
    err       = err_q;
  end

  // Request latch, wait counter and read-data register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_rd   <= 1'b0;
      err_q   <= 1'b0;
      MDataIn <= '0;
    end else begin
      err_q <= (state == ST_IDLE) && read && write;
      if (accept) begin
        addr_q  <= marOut;
        wdata_q <= mdrOut;
        op_rd   <= read;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ST_XFER && op_rd) MDataIn <= ram[addr_q];
    end
  end

  // RAM has no reset. A reset during WAIT or XFER has already forced the state
  // back to IDLE, so an aborted write never reaches the array. The clear term
  // also covers a reset that coincides with the XFER edge.
  always_ff @(posedge clk) begin
    if (!clear && state == ST_XFER && !op_rd) ram[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        clear;
  logic [8:0]  marOut;
  logic [31:0] mdrOut;
  logic        read, write;
  logic [31:0] MDataIn;
  logic        mdrRead, mdrEnable, busy, done, err;

  logic [8:0]  marOut0;
  logic [31:0] mdrOut0;
  logic        read0, write0;
  logic [31:0] MDataIn0;
  logic        mdrRead0, mdrEnable0, busy0, done0, err0;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain word array plus a record of which words were written.
  logic [31:0] model [512];
  bit          valid [512];
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  mem_ctrl #(.BITS(32), .ADDR_BITS(9), .WAIT_STATES(W)) dut (
    .clk(clk), .clear(clear), .marOut(marOut), .mdrOut(mdrOut),
    .read(read), .write(write), .MDataIn(MDataIn), .mdrRead(mdrRead),
    .mdrEnable(mdrEnable), .busy(busy), .done(done), .err(err)
  );

  mem_ctrl #(.BITS(32), .ADDR_BITS(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .clear(clear), .marOut(marOut0), .mdrOut(mdrOut0),
    .read(read0), .write(write0), .MDataIn(MDataIn0), .mdrRead(mdrRead0),
    .mdrEnable(mdrEnable0), .busy(busy0), .done(done0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the W-wait-state instance. After acceptance marOut is moved
  // to alt_addr and mdrOut is scrambled, so the latched values must be used.
  task automatic access(input bit is_rd, input logic [8:0] a, input logic [31:0] d,
                        input logic [8:0] alt_addr);
    int cycles;
    @(negedge clk);
    read = is_rd; write = !is_rd; marOut = a; mdrOut = d;
    @(negedge clk);
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    marOut = alt_addr; mdrOut = $urandom;
    cycles = 1;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("latency", cycles, W + 2);
    chk("busy_in_done", {31'b0, busy}, 32'd1);
    chk("mdrRead", {31'b0, mdrRead}, {31'b0, is_rd});
    chk("mdrEnable", {31'b0, mdrEnable}, {31'b0, is_rd});
    if (is_rd) last_rd = model[a];
    else begin
      model[a] = d;
      valid[a] = 1'b1;
    end
    chk(is_rd ? "read_data" : "data_held_on_write", MDataIn, last_rd);
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("idle_after_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Reset with random inputs: outputs must clear immediately.
    clear = 1'b1;
    read = 1'($urandom); write = 1'($urandom); marOut = 9'($urandom); mdrOut = $urandom;
    read0 = 1'b0; write0 = 1'b0; marOut0 = '0; mdrOut0 = '0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_mdatain", MDataIn, 32'd0);
    chk("rst_mdrread", {31'b0, mdrRead}, 32'd0);
    chk("rst_mdrenable", {31'b0, mdrEnable}, 32'd0);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    clear = 1'b0;

    // Write then read back the same word.
    access(1'b0, 9'h010, 32'hDEADBEEF, 9'h000);
    access(1'b1, 9'h010, 32'h0, 9'h000);

    // Simultaneous read and write is rejected.
    @(negedge clk);
    read = 1'b1; write = 1'b1; marOut = 9'h010; mdrOut = 32'h0BAD0BAD;
    @(negedge clk);
    chk("err_pulse", {31'b0, err}, 32'd1);
    chk("err_busy", {31'b0, busy}, 32'd0);
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    chk("err_one_cycle", {31'b0, err}, 32'd0);
    access(1'b1, 9'h010, 32'h0, 9'h000);

    // A reset during WAIT aborts the write.
    access(1'b0, 9'h011, 32'hAAAA5555, 9'h000);
    @(negedge clk);
    write = 1'b1; marOut = 9'h011; mdrOut = 32'h12345678;
    @(negedge clk);
    chk("abort_busy_wait", {31'b0, busy}, 32'd1);
    clear = 1'b1; write = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'b0, done}, 32'd0);
    end
    last_rd = 32'h0;
    access(1'b1, 9'h011, 32'h0, 9'h000);

    // The highest and lowest addresses are distinct, and the address is latched at acceptance.
    access(1'b0, 9'h1FF, 32'hCAFEF00D, 9'h000);
    access(1'b0, 9'h000, 32'h01234567, 9'h1FF);
    access(1'b1, 9'h1FF, 32'h0, 9'h000);
    access(1'b1, 9'h000, 32'h0, 9'h1FF);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      logic [8:0]  a;
      bit          rd;
      a  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 1) * 9'h1FF)
                                       : 9'($urandom_range(0, 511));
      rd = 1'($urandom) && valid[a];
      access(rd, a, $urandom, 9'($urandom));
    end

    // Zero-wait instance with read held high: XFER, DONE, IDLE repeating.
    @(negedge clk);
    read0 = 1'b1; marOut0 = 9'h005;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("w0_done", {31'b0, done0}, {31'b0, (k % 3) == 2});
      chk("w0_busy", {31'b0, busy0}, {31'b0, (k % 3) != 0});
      chk("w0_mdren", {31'b0, mdrEnable0}, {31'b0, (k % 3) == 2});
    end
    read0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("w0_idle", {31'b0, busy0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
